// File: rtl/register_file_sb.sv
// register_file_sb: parametrised 2-read/1-write register file for the pipelined core.
// Adds a per-register pending-write scoreboard with a running pending count, an
// optional hard-wired zero register, optional write-to-read bypass, and a post-reset
// sequencer that zeroes the array one entry per cycle before the file goes live.
module register_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] a1_i,
  input  logic [ADDR_WIDTH-1:0] a2_i,
  output logic [DATA_WIDTH-1:0] rd1_o,
  output logic [DATA_WIDTH-1:0] rd2_o,
  output logic                  rd1_ready_o,
  output logic                  rd2_ready_o,
  input  logic                  we3_i,
  input  logic [ADDR_WIDTH-1:0] a3_i,
  input  logic [DATA_WIDTH-1:0] wd3_i,
  input  logic                  issue_we_i,
  input  logic [ADDR_WIDTH-1:0] issue_rd_i,
  output logic                  init_done_o,
  output logic [ADDR_WIDTH:0]   pending_count_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, IDLE} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_idx_q;
  logic                    init_done_q;
  logic [DEPTH-1:0]        busy_q, busy_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic wr_en;
  logic issue_en;
  logic wr_hits_rd1, wr_hits_rd2;
  logic zero_rd1, zero_rd2;

  // Writes and issues only take effect once the clear sequence has finished;
  // the zero register can never become pending.
  assign wr_en    = init_done_q & we3_i & ~reset_i;
  assign issue_en = init_done_q & issue_we_i & ~(ZERO_REG & (issue_rd_i == '0));

  assign wr_hits_rd1 = BYPASS & we3_i & (a3_i == a1_i);
  assign wr_hits_rd2 = BYPASS & we3_i & (a3_i == a2_i);
  assign zero_rd1    = ZERO_REG & (a1_i == '0);
  assign zero_rd2    = ZERO_REG & (a2_i == '0);

  // Scoreboard next state: writeback clears, issue sets (issue wins on a tie);
  // the counter tracks only real 0->1 and 1->0 transitions so it equals the popcount.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (wr_en) busy_d[a3_i] = 1'b0;
    if (issue_en) busy_d[issue_rd_i] = 1'b1;
    if (issue_en && !busy_q[issue_rd_i]) cnt_d = cnt_d + 1'b1;
    if (wr_en && busy_q[a3_i] && !(issue_en && (issue_rd_i == a3_i))) cnt_d = cnt_d - 1'b1;
  end

  // Control FSM: reset restarts the clear sweep; IDLE commits scoreboard updates.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= CLEAR;
      clr_idx_q   <= '0;
      init_done_q <= 1'b0;
      busy_q      <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == '1) begin
            state_q     <= IDLE;
            init_done_q <= 1'b1;
          end
        end
        IDLE: begin
          busy_q <= busy_d;
          cnt_q  <= cnt_d;
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Register array: zeroed by the sweep during CLEAR, written by writeback in IDLE.
  always_ff @(posedge clk_i) begin
    if (!reset_i && state_q == CLEAR) begin
      mem_q[clr_idx_q] <= '0;
    end else if (wr_en && !(ZERO_REG && (a3_i == '0))) begin
      mem_q[a3_i] <= wd3_i;
    end
  end

  // Combinational read ports, forced to 0 until the array has been cleared.
  always_comb begin
    rd1_o = '0;
    rd2_o = '0;
    if (init_done_q) begin
      rd1_o = zero_rd1 ? '0 : (wr_hits_rd1 ? wd3_i : mem_q[a1_i]);
      rd2_o = zero_rd2 ? '0 : (wr_hits_rd2 ? wd3_i : mem_q[a2_i]);
    end
  end

  assign rd1_ready_o     = init_done_q & (~busy_q[a1_i] | wr_hits_rd1 | zero_rd1);
  assign rd2_ready_o     = init_done_q & (~busy_q[a2_i] | wr_hits_rd2 | zero_rd2);
  assign init_done_o     = init_done_q;
  assign pending_count_o = cnt_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Testbench for register_file_sb: directed stimulus pushes expected outputs into a
// scoreboard queue; a negedge monitor pops and compares them. A second instance with
// BYPASS=0 shares all inputs to cover the non-bypassed read timing.
module tb_register_file_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = -1;  // don't-care marker for an expected field

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i, we3, issue_we;
  logic [AW-1:0] a1, a2, a3, issue_rd;
  logic [DW-1:0] wd3;
  logic [DW-1:0] rd1, rd2, nb_rd1, nb_rd2;
  logic          r1, r2, done, nb_r1, nb_r2, nb_done;
  logic [AW:0]   cnt, nb_cnt;

  register_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk_i(clk), .reset_i(reset_i), .a1_i(a1), .a2_i(a2), .rd1_o(rd1), .rd2_o(rd2),
    .rd1_ready_o(r1), .rd2_ready_o(r2), .we3_i(we3), .a3_i(a3), .wd3_i(wd3),
    .issue_we_i(issue_we), .issue_rd_i(issue_rd), .init_done_o(done), .pending_count_o(cnt));

  register_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk_i(clk), .reset_i(reset_i), .a1_i(a1), .a2_i(a2), .rd1_o(nb_rd1), .rd2_o(nb_rd2),
    .rd1_ready_o(nb_r1), .rd2_ready_o(nb_r2), .we3_i(we3), .a3_i(a3), .wd3_i(wd3),
    .issue_we_i(issue_we), .issue_rd_i(issue_rd), .init_done_o(nb_done), .pending_count_o(nb_cnt));

  typedef struct {
    string name;
    int rd1; int rd2; int r1; int r2; int done; int cnt; int nb1; int nb2;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string nm, string f, logic [31:0] act, int exp_v);
    if (exp_v >= 0) begin
      n_checks++;
      if (act !== 32'(exp_v)) begin
        n_fail++;
        $display("FAIL %s.%s: got %0d expected %0d", nm, f, act, exp_v);
      end
    end
  endtask

  // Monitor: at each falling edge, check every expectation queued for this cycle.
  exp_t e;
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.name, "rd1", rd1, e.rd1);
      chk(e.name, "rd2", rd2, e.rd2);
      chk(e.name, "rdy1", 32'(r1), e.r1);
      chk(e.name, "rdy2", 32'(r2), e.r2);
      chk(e.name, "init_done", 32'(done), e.done);
      chk(e.name, "pending", 32'(cnt), e.cnt);
      chk(e.name, "nb_rd1", nb_rd1, e.nb1);
      chk(e.name, "nb_rd2", nb_rd2, e.nb2);
      chk(e.name, "nb_init_done", 32'(nb_done), e.done);
      chk(e.name, "nb_pending", 32'(nb_cnt), e.cnt);
      if (!we3) begin
        chk(e.name, "nb_rdy1", 32'(nb_r1), e.r1);
        chk(e.name, "nb_rdy2", 32'(nb_r2), e.r2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(string nm, int x_rd1, int x_rd2, int x_r1, int x_r2,
                          int x_done, int x_cnt, int x_nb1, int x_nb2);
    exp_t t;
    t.name = nm; t.rd1 = x_rd1; t.rd2 = x_rd2; t.r1 = x_r1; t.r2 = x_r2;
    t.done = x_done; t.cnt = x_cnt; t.nb1 = x_nb1; t.nb2 = x_nb2;
    sb_q.push_back(t);
  endtask

  // n cycles of CLEAR with write/issue attempts that must be ignored.
  task automatic clear_run(string nm, int n);
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEAD; issue_we = 1'b1; issue_rd = 5'd6;
    a1 = 5'd5; a2 = 5'd6;
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      expect_o(nm, 0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    reset_i = 1'b1; we3 = 1'b0; issue_we = 1'b0;
    a1 = '0; a2 = '0; a3 = '0; wd3 = '0; issue_rd = '0;

    // Reset and first clear sweep
    step(); expect_o("rst1", 0, 0, 0, 0, 0, 0, 0, 0);
    step(); expect_o("rst2", 0, 0, 0, 0, 0, 0, 0, 0);
    reset_i = 1'b0;
    clear_run("clear1", 32);
    step(); we3 = 1'b0; issue_we = 1'b0;
    expect_o("done1", 0, 0, 1, 1, 1, 0, 0, 0);

    // Bypass vs. non-bypass on x3
    step(); we3 = 1'b1; a3 = 5'd3; wd3 = 32'd12345; a1 = 5'd3; a2 = 5'd3;
    expect_o("byp_same", 12345, 12345, 1, 1, 1, 0, 0, 0);
    step(); we3 = 1'b0;
    expect_o("byp_next", 12345, 12345, 1, 1, 1, 0, 12345, 12345);

    // Fill x1..x31 with 1000+i, then read everything back
    for (int i = 1; i < 32; i++) begin
      step(); we3 = 1'b1; a3 = AW'(i); wd3 = DW'(1000 + i); a1 = AW'(i); a2 = AW'(i - 1);
      expect_o("fill", 1000 + i, (i == 1) ? 0 : 999 + i, 1, 1, 1, 0,
               (i == 3) ? 12345 : 0, (i == 1) ? 0 : 999 + i);
    end
    for (int i = 0; i < 32; i++) begin
      step(); we3 = 1'b0; a1 = AW'(i); a2 = AW'(31 - i);
      expect_o("readback", (i == 0) ? 0 : 1000 + i, (i == 31) ? 0 : 1031 - i, 1, 1, 1, 0,
               (i == 0) ? 0 : 1000 + i, (i == 31) ? 0 : 1031 - i);
    end

    // Zero register: writes and issues to x0 have no effect
    step(); we3 = 1'b1; a3 = '0; wd3 = 32'd9876; a1 = '0; a2 = '0;
    expect_o("x0_write", 0, 0, 1, 1, 1, 0, 0, 0);
    step(); we3 = 1'b0; issue_we = 1'b1; issue_rd = '0;
    expect_o("x0_issue", 0, 0, 1, 1, 1, 0, 0, 0);
    step(); issue_we = 1'b0;
    expect_o("x0_after", 0, 0, 1, 1, 1, 0, 0, 0);

    // Scoreboard: issue x5, then writeback
    step(); issue_we = 1'b1; issue_rd = 5'd5; a1 = 5'd5; a2 = 5'd5;
    expect_o("sb_issue", 1005, 1005, 1, 1, 1, 0, 1005, 1005);
    step(); issue_we = 1'b0;
    expect_o("sb_busy", 1005, 1005, 0, 0, 1, 1, 1005, 1005);
    step(); we3 = 1'b1; a3 = 5'd5; wd3 = 32'd555;
    expect_o("sb_wb", 555, 555, 1, 1, 1, 1, 1005, 1005);
    step(); we3 = 1'b0;
    expect_o("sb_clear", 555, 555, 1, 1, 1, 0, 555, 555);

    // Simultaneous issue and write
    step(); issue_we = 1'b1; issue_rd = 5'd7; a1 = 5'd7; a2 = 5'd9;
    expect_o("sim_i7", 1007, 1009, 1, 1, 1, 0, 1007, 1009);
    step(); issue_rd = 5'd9;
    expect_o("sim_i9", 1007, 1009, 0, 1, 1, 1, 1007, 1009);
    step(); issue_rd = 5'd7; we3 = 1'b1; a3 = 5'd7; wd3 = 32'd777;
    expect_o("sim_same", 777, 1009, 1, 0, 1, 2, 1007, 1009);
    step(); issue_rd = 5'd8; a3 = 5'd9; wd3 = 32'd999;
    expect_o("sim_diff", 777, 999, 0, 1, 1, 2, 777, 1009);
    step(); we3 = 1'b0; issue_we = 1'b0; a1 = 5'd8; a2 = 5'd9;
    expect_o("sim_after", 1008, 999, 0, 1, 1, 2, 1008, 999);
    step(); we3 = 1'b1; a3 = 5'd7; wd3 = 32'd7007; a1 = 5'd7; a2 = 5'd8;
    expect_o("wb_x7", 7007, 1008, 1, 0, 1, 2, 777, 1008);
    step(); a3 = 5'd8; wd3 = 32'd8008;
    expect_o("wb_x8", 7007, 8008, 1, 1, 1, 1, 7007, 1008);
    step(); we3 = 1'b0;
    expect_o("wb_done", 7007, 8008, 1, 1, 1, 0, 7007, 8008);

    // Saturation: issue every register, then re-issue and issue x0
    for (int i = 1; i < 32; i++) begin
      step(); issue_we = 1'b1; issue_rd = AW'(i); a1 = AW'(i); a2 = '0;
      expect_o("sat_issue", D, 0, 1, 1, 1, i - 1, D, 0);
    end
    step(); issue_rd = 5'd4; a1 = 5'd4; a2 = 5'd31;
    expect_o("sat_reissue", 1004, 1031, 0, 0, 1, 31, 1004, 1031);
    step(); issue_rd = '0; a1 = '0; a2 = 5'd4;
    expect_o("sat_x0", 0, 1004, 1, 0, 1, 31, 0, 1004);
    step(); issue_we = 1'b0;
    expect_o("sat_hold", 0, 1004, 1, 0, 1, 31, 0, 1004);

    // Reset from a full scoreboard, interrupted clear, full clear
    step(); reset_i = 1'b1; a1 = 5'd3; a2 = 5'd4;
    expect_o("rst_pre", D, D, D, D, 1, 31, D, D);
    step(); expect_o("rst3", 0, 0, 0, 0, 0, 0, 0, 0);
    reset_i = 1'b0;
    clear_run("clear2", 10);
    reset_i = 1'b1;
    step(); expect_o("rst4", 0, 0, 0, 0, 0, 0, 0, 0);
    reset_i = 1'b0;
    clear_run("clear3", 32);
    step(); we3 = 1'b0; issue_we = 1'b0;
    expect_o("done3", 0, 0, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      step(); a1 = AW'(i); a2 = AW'(31 - i);
      expect_o("cleared", 0, 0, 1, 1, 1, 0, 0, 0);
    end

    step(); step();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
